// File: rtl/axi_wdata_chs.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wdata_chs
//  Purpose  : AXI write-data channel shaper. Buffers W beats from the app side
//             in a first-word-fall-through FIFO and, per accepted burst
//             command, either forwards one burst to the memory controller
//             (PASS) or drains and discards it, then answers the app with a
//             DECERR B response (DROP).
//  Ports    : clk, reset_ (async, active-low)
//             in_w*/in_swvalid/out_swready   app W beats in
//             out_w*/out_mwvalid/in_mwready  W beats to memory controller
//             cmd_*                          burst command (from AW path)
//             out_b*/in_bready               B response for dropped bursts
//             drop_done                      pulse on drop B handshake
//             wlast_err                      sticky wlast/len disagreement
//  Revision : 1.0 - initial release
// ============================================================================
module axi_wdata_chs #(
  parameter int BUF_SZ   = 256,
  parameter int ID_WID   = 8,
  parameter int DATA_WID = 32,
  parameter int USER_WID = 2
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [DATA_WID-1:0]     in_wdata,
  input  logic [DATA_WID/8-1:0]   in_wstrb,
  input  logic                    in_wlast,
  input  logic                    in_swvalid,
  output logic                    out_swready,
  output logic [DATA_WID-1:0]     out_wdata,
  output logic [DATA_WID/8-1:0]   out_wstrb,
  output logic                    out_wlast,
  output logic                    out_mwvalid,
  input  logic                    in_mwready,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_drop,
  input  logic [ID_WID-1:0]       cmd_id,
  input  logic [USER_WID-1:0]     cmd_user,
  input  logic [7:0]              cmd_len,
  output logic [ID_WID-1:0]       out_bid,
  output logic [USER_WID-1:0]     out_buser,
  output logic [1:0]              out_bresp,
  output logic                    out_bvalid,
  input  logic                    in_bready,
  output logic                    drop_done,
  output logic                    wlast_err
);

  localparam int c_aw    = $clog2(BUF_SZ);
  localparam int c_strb_w = DATA_WID / 8;
  localparam int c_ent_w  = c_strb_w + DATA_WID + 1;
  localparam logic [c_aw:0] c_full_cnt = (c_aw + 1)'(BUF_SZ);
  localparam logic [1:0]    c_decerr   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DROP  = 2'd2,
    S_BRESP = 2'd3
  } state_t;

  state_t r_state;

  // --------------------------------------------------------------------------
  // W FIFO: entry = {wstrb, wdata, wlast}; head is read combinationally.
  // --------------------------------------------------------------------------
  logic [c_ent_w-1:0] r_mem [BUF_SZ];
  logic [c_aw-1:0]    r_wr_ptr;
  logic [c_aw-1:0]    r_rd_ptr;
  logic [c_aw:0]      r_count;
  logic [c_aw:0]      w_count_nxt;
  logic               r_full;
  logic               r_empty;
  logic               w_push;
  logic               w_pop;
  logic [c_ent_w-1:0] w_head;
  logic               w_head_last;

  assign w_push      = in_swvalid & ~r_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_last = w_head[0];

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_PASS:  w_pop = ~r_empty & in_mwready;
      S_DROP:  w_pop = ~r_empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage is not reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_wstrb, in_wdata, in_wlast};
    end
  end

  // Pointer width equals log2(BUF_SZ), so increments wrap modulo depth.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_full_cnt);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // --------------------------------------------------------------------------
  // Burst control
  // --------------------------------------------------------------------------
  logic [ID_WID-1:0]   r_id;
  logic [USER_WID-1:0] r_user;
  logic [7:0]          r_len;
  logic [7:0]          r_beat_cnt;
  logic [ID_WID-1:0]   r_bid;
  logic [USER_WID-1:0] r_buser;
  logic [1:0]          r_bresp;
  logic                r_bvalid;
  logic                r_drop_done;
  logic                r_wlast_err;
  logic                w_last_hit;
  logic                w_mismatch;

  assign w_last_hit = (r_beat_cnt == r_len);
  // Either an early wlast or a missing wlast on the final counted beat.
  assign w_mismatch = w_head_last ^ w_last_hit;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_user      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_bid       <= '0;
      r_buser     <= '0;
      r_bresp     <= '0;
      r_bvalid    <= 1'b0;
      r_drop_done <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      r_drop_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_id       <= cmd_id;
            r_user     <= cmd_user;
            r_len      <= cmd_len;
            r_beat_cnt <= '0;
            r_state    <= cmd_drop ? S_DROP : S_PASS;
          end
        end
        S_PASS: begin
          // Forwarded bursts always end on wlast; the MC owns the B response.
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_mismatch) r_wlast_err <= 1'b1;
            if (w_head_last) r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          // Discarded bursts end at whichever comes first: wlast or len.
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_mismatch) r_wlast_err <= 1'b1;
            if (w_head_last || w_last_hit) begin
              r_bvalid <= 1'b1;
              r_bresp  <= c_decerr;
              r_bid    <= r_id;
              r_buser  <= r_user;
              r_state  <= S_BRESP;
            end
          end
        end
        S_BRESP: begin
          if (in_bready) begin
            r_bvalid    <= 1'b0;
            r_drop_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_swready = ~r_full;
  assign out_mwvalid = (r_state == S_PASS) & ~r_empty;
  assign out_wstrb   = w_head[c_ent_w-1 -: c_strb_w];
  assign out_wdata   = w_head[DATA_WID:1];
  assign out_wlast   = w_head_last;
  assign cmd_ready   = (r_state == S_IDLE);
  assign out_bid     = r_bid;
  assign out_buser   = r_buser;
  assign out_bresp   = r_bresp;
  assign out_bvalid  = r_bvalid;
  assign drop_done   = r_drop_done;
  assign wlast_err   = r_wlast_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_chs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_wdata_chs
//  Purpose  : Self-checking bench for axi_wdata_chs. A queue holds every beat
//             the app has handed over and not yet consumed; bursts are
//             consumed from it by the command rules (PASS: handshake order,
//             DROP: up to first wlast or len+1 beats).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wdata_chs;

  localparam int BUF_SZ   = 16;
  localparam int ID_WID   = 8;
  localparam int DATA_WID = 32;
  localparam int USER_WID = 2;
  localparam int STRB_W   = DATA_WID / 8;

  logic                  clk = 1'b0;
  logic                  reset_;
  logic [DATA_WID-1:0]   in_wdata;
  logic [STRB_W-1:0]     in_wstrb;
  logic                  in_wlast;
  logic                  in_swvalid;
  logic                  out_swready;
  logic [DATA_WID-1:0]   out_wdata;
  logic [STRB_W-1:0]     out_wstrb;
  logic                  out_wlast;
  logic                  out_mwvalid;
  logic                  in_mwready;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_drop;
  logic [ID_WID-1:0]     cmd_id;
  logic [USER_WID-1:0]   cmd_user;
  logic [7:0]            cmd_len;
  logic [ID_WID-1:0]     out_bid;
  logic [USER_WID-1:0]   out_buser;
  logic [1:0]            out_bresp;
  logic                  out_bvalid;
  logic                  in_bready;
  logic                  drop_done;
  logic                  wlast_err;

  always #5 clk = ~clk;

  axi_wdata_chs #(
    .BUF_SZ(BUF_SZ), .ID_WID(ID_WID), .DATA_WID(DATA_WID), .USER_WID(USER_WID)
  ) dut (
    .clk(clk), .reset_(reset_),
    .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .in_swvalid(in_swvalid), .out_swready(out_swready),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
    .out_mwvalid(out_mwvalid), .in_mwready(in_mwready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_drop(cmd_drop),
    .cmd_id(cmd_id), .cmd_user(cmd_user), .cmd_len(cmd_len),
    .out_bid(out_bid), .out_buser(out_buser), .out_bresp(out_bresp),
    .out_bvalid(out_bvalid), .in_bready(in_bready),
    .drop_done(drop_done), .wlast_err(wlast_err)
  );

  typedef logic [STRB_W+DATA_WID:0] beat_t;   // {strb, data, last}

  beat_t      q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         pass_mode, drop_mode, exp_err, pend_err, exp_dd;
  int         pass_idx;
  logic [7:0] pass_len;
  int         n_out;
  int         base;
  int         pushed;
  logic [7:0] rid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Handshakes are judged on values held before the edge;
  // the model is updated accordingly and outputs are checked #1 after it.
  task automatic step();
    bit    push, pop, acc, hs;
    beat_t b;
    push = in_swvalid && out_swready;
    pop  = out_mwvalid && in_mwready;
    acc  = cmd_valid && cmd_ready;
    hs   = out_bvalid && in_bready;
    if (pop) begin
      chk("beat_expected", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        b = q.pop_front();
        chk("mc_beat", {out_wstrb, out_wdata, out_wlast}, b);
        if (b[0] != (pass_idx == int'(pass_len))) exp_err = 1;
        pass_idx++;
        n_out++;
        if (b[0]) pass_mode = 0;
      end
    end
    if (acc) begin
      if (cmd_drop) begin
        drop_mode = 1;
        pend_err  = 0;
        for (int k = 0; k <= int'(cmd_len); k++) begin
          if (q.size() == 0) break;
          b = q.pop_front();
          if (b[0] != (k == int'(cmd_len))) pend_err = 1;
          if (b[0]) break;
        end
      end else begin
        pass_mode = 1;
        pass_idx  = 0;
        pass_len  = cmd_len;
      end
    end
    if (push) q.push_back({in_wstrb, in_wdata, in_wlast});
    exp_dd = hs;
    @(posedge clk);
    #1;
    if (drop_mode && out_bvalid) begin
      drop_mode = 0;
      if (pend_err) exp_err = 1;
    end
    chk("swready", {63'd0, out_swready}, {63'd0, q.size() < BUF_SZ});
    chk("mwvalid", {63'd0, out_mwvalid}, {63'd0, pass_mode && q.size() != 0});
    chk("wlast_err", {63'd0, wlast_err}, {63'd0, exp_err});
    chk("drop_done", {63'd0, drop_done}, {63'd0, exp_dd});
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    in_swvalid = 1'b1;
    in_wdata   = d;
    in_wstrb   = s;
    in_wlast   = l;
    step();
    in_swvalid = 1'b0;
  endtask

  task automatic send_cmd(input logic drop, input logic [7:0] id, input logic [1:0] user,
                          input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_drop  = drop;
    cmd_id    = id;
    cmd_user  = user;
    cmd_len   = len;
    chk("cmd_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain_pass();
    for (int t = 0; t < 200 && pass_mode; t++) step();
    chk("pass_done", {63'd0, pass_mode}, 64'd0);
  endtask

  task automatic wait_b();
    for (int t = 0; t < 60 && !out_bvalid; t++) step();
    chk("bvalid", {63'd0, out_bvalid}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_ = 0; in_wdata = '0; in_wstrb = '0; in_wlast = 0; in_swvalid = 0;
    in_mwready = 0; cmd_valid = 0; cmd_drop = 0; cmd_id = '0; cmd_user = '0;
    cmd_len = '0; in_bready = 0;
    pass_mode = 0; drop_mode = 0; exp_err = 0; pend_err = 0; exp_dd = 0;
    pass_idx = 0; pass_len = '0; n_out = 0;
    #1;
    chk("rst_mwvalid", {63'd0, out_mwvalid}, 64'd0);
    chk("rst_swready", {63'd0, out_swready}, 64'd1);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_bvalid", {63'd0, out_bvalid}, 64'd0);
    chk("rst_bresp", {62'd0, out_bresp}, 64'd0);
    chk("rst_wlast_err", {63'd0, wlast_err}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_ = 1;
    step();

    // 1: PASS 4 beats A0..A3, MC always ready
    in_mwready = 1;
    base = n_out;
    send_cmd(0, 8'h11, 2'd1, 8'd3);
    for (int i = 0; i < 4; i++) push_beat(32'hA0 + i, 4'hF, i == 3);
    drain_pass();
    chk("t1_beats", n_out - base, 64'd4);
    chk("t1_idle", {63'd0, cmd_ready}, 64'd1);

    // 2: fill to BUF_SZ without a command, then forward it
    for (int i = 0; i < BUF_SZ; i++) push_beat($urandom, 4'($urandom), i == BUF_SZ - 1);
    chk("t2_full", {63'd0, out_swready}, 64'd0);
    push_beat($urandom, 4'hF, 1'b0);          // refused while full
    base = n_out;
    send_cmd(0, 8'h22, 2'd0, 8'(BUF_SZ - 1));
    step();
    chk("t2_ready_back", {63'd0, out_swready}, 64'd1);
    drain_pass();
    chk("t2_beats", n_out - base, BUF_SZ);

    // 3: DROP len=7 with 2 beats of the next burst queued behind it
    in_mwready = 0;
    for (int i = 0; i < 8; i++) push_beat($urandom, 4'($urandom), i == 7);
    for (int i = 0; i < 2; i++) push_beat($urandom, 4'($urandom), i == 1);
    send_cmd(1, 8'h05, 2'd2, 8'd7);
    wait_b();
    chk("t3_bid", {56'd0, out_bid}, 64'h05);
    chk("t3_buser", {62'd0, out_buser}, 64'd2);
    chk("t3_bresp", {62'd0, out_bresp}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_b_hold", {63'd0, out_bvalid}, 64'd1);
    end
    in_bready = 1;
    step();
    in_bready = 0;
    chk("t3_b_clear", {63'd0, out_bvalid}, 64'd0);
    step();
    chk("t3_idle", {63'd0, cmd_ready}, 64'd1);
    in_mwready = 1;
    base = n_out;
    send_cmd(0, 8'h33, 2'd3, 8'd1);
    drain_pass();
    chk("t3_survivors", n_out - base, 64'd2);

    // 4: PASS 12 beats, MC ready toggling, app pushing randomly alongside
    base = n_out;
    pushed = 0;
    send_cmd(0, 8'h44, 2'd1, 8'd11);
    for (int t = 0; t < 300 && (pushed < 12 || pass_mode); t++) begin
      in_mwready = t[0];
      in_swvalid = (pushed < 12) && ($urandom_range(0, 3) != 0);
      in_wdata   = $urandom;
      in_wstrb   = 4'($urandom);
      in_wlast   = (pushed == 11);
      if (in_swvalid && out_swready) pushed++;
      step();
    end
    in_swvalid = 0;
    in_mwready = 1;
    chk("t4_beats", n_out - base, 64'd12);
    chk("t4_empty", q.size(), 64'd0);

    // 5: DROP len=3 but wlast on beat 2
    chk("t5_err_before", {63'd0, wlast_err}, 64'd0);
    for (int i = 0; i < 3; i++) push_beat($urandom, 4'hF, i == 2);
    rid = 8'($urandom_range(1, 255));
    send_cmd(1, rid, 2'd1, 8'd3);
    wait_b();
    chk("t5_err", {63'd0, wlast_err}, 64'd1);
    chk("t5_bid", {56'd0, out_bid}, {56'd0, rid});
    chk("t5_bresp", {62'd0, out_bresp}, 64'd3);
    in_bready = 1;
    step();
    in_bready = 0;
    step();
    chk("t5_fifo_empty", {63'd0, out_swready}, 64'd1);

    // 6: asynchronous reset in the middle of a PASS burst
    for (int i = 0; i < 4; i++) push_beat($urandom, 4'hF, i == 3);
    base = n_out;
    send_cmd(0, 8'h66, 2'd2, 8'd3);
    for (int t = 0; t < 20 && (n_out - base) < 2; t++) step();
    chk("t6_two_out", n_out - base, 64'd2);
    #2;
    reset_ = 0;
    #1;
    chk("t6_mwvalid", {63'd0, out_mwvalid}, 64'd0);
    chk("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("t6_bid", {56'd0, out_bid}, 64'd0);
    chk("t6_wlast_err", {63'd0, wlast_err}, 64'd0);
    q.delete();
    pass_mode = 0; drop_mode = 0; exp_err = 0;
    @(posedge clk); #1;
    reset_ = 1;
    step();
    base = n_out;
    send_cmd(0, 8'h77, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) step();        // FIFO must be empty: no valid
    push_beat(32'hDEADBEEF, 4'h5, 1'b1);
    drain_pass();
    chk("t6_post_beats", n_out - base, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
